// File: rtl/mire_writer.sv
// mire_writer: Wishbone master that paints a grid + gradient test pattern
// into the framebuffer, one 32-bit word per pixel in raster order. It gives
// up the bus for one cycle after every BURST words so the scan-out reader
// sharing the SDRAM is never starved.
module mire_writer #(
  parameter int unsigned HDISP      = 800,
  parameter int unsigned VDISP      = 480,
  parameter logic [31:0] BASE       = 32'h0,
  parameter int unsigned BURST      = 64,
  parameter int unsigned CONTINUOUS = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [31:0] adr,
  output logic [31:0] dat_ms,
  output logic        we,
  output logic [3:0]  sel,
  output logic        stb,
  output logic        cyc,
  output logic [2:0]  cti,
  output logic [1:0]  bte,
  input  logic        ack,
  output logic        frame_done
);

  localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int BW = $clog2(BURST + 1);

  localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BURST - 1);

  typedef enum logic [1:0] {IDLE, WRITE, PAUSE} state_t;

  state_t        state;
  logic [XW-1:0] x, x_nxt;
  logic [YW-1:0] y, y_nxt;
  logic [BW-1:0] bcnt;
  logic          x_wrap, last_px, burst_hit;

  // Grid lines every 16 pixels in white, elsewhere a coordinate gradient.
  function automatic logic [31:0] pattern(input logic [XW-1:0] px,
                                          input logic [YW-1:0] py);
    logic [7:0] x8, y8;
    x8 = 8'(px);
    y8 = 8'(py);
    if (x8[3:0] == 4'd0 || y8[3:0] == 4'd0) return 32'h00FF_FFFF;
    return {8'h00, x8, y8, 8'h80};
  endfunction

  assign sel = 4'b1111;
  assign cti = 3'd0;
  assign bte = 2'd0;

  // Raster position of the pixel after the current one (wraps to 0,0 at frame end).
  always_comb begin
    x_wrap    = (x == X_LAST);
    last_px   = x_wrap && (y == Y_LAST);
    burst_hit = (bcnt == B_LAST);
    x_nxt     = x_wrap ? '0 : x + 1'b1;
    y_nxt     = y;
    if (x_wrap) y_nxt = last_px ? '0 : y + 1'b1;
  end

  // Write FSM; every bus output is registered so ack never reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cyc        <= 1'b0;
      stb        <= 1'b0;
      we         <= 1'b0;
      adr        <= BASE;
      x          <= '0;
      y          <= '0;
      bcnt       <= '0;
      frame_done <= 1'b0;
      dat_ms     <= pattern('0, '0);
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) begin
            state <= WRITE;
            cyc   <= 1'b1;
            stb   <= 1'b1;
            we    <= 1'b1;
          end
        end
        WRITE: begin
          // adr/dat_ms only move on ack, so they are stable while the slave waits.
          if (ack) begin
            x      <= x_nxt;
            y      <= y_nxt;
            dat_ms <= pattern(x_nxt, y_nxt);
            if (last_px) begin
              // Frame end outranks burst end; position rewinds to the origin.
              adr        <= BASE;
              bcnt       <= '0;
              frame_done <= 1'b1;
              cyc        <= 1'b0;
              stb        <= 1'b0;
              we         <= 1'b0;
              state      <= (CONTINUOUS != 0 && enable) ? PAUSE : IDLE;
            end else begin
              adr <= adr + 32'd4;
              if (!enable) begin
                // Position and burst count survive so re-enable resumes in place.
                bcnt  <= burst_hit ? '0 : bcnt + 1'b1;
                cyc   <= 1'b0;
                stb   <= 1'b0;
                we    <= 1'b0;
                state <= IDLE;
              end else if (burst_hit) begin
                bcnt  <= '0;
                cyc   <= 1'b0;
                stb   <= 1'b0;
                we    <= 1'b0;
                state <= PAUSE;
              end else begin
                bcnt <= bcnt + 1'b1;
              end
            end
          end
        end
        PAUSE: begin
          // One released cycle lets the arbiter grant the reader.
          if (enable) begin
            state <= WRITE;
            cyc   <= 1'b1;
            stb   <= 1'b1;
            we    <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cyc   <= 1'b0;
          stb   <= 1'b0;
          we    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mire_writer.sv
// tb_mire_writer: two writers on a small 32x4 frame. u0 is single-shot with
// long bursts, u1 is continuous with 8-word bursts. A scoreboard queue per
// writer holds the expected (adr, data) sequence; monitors pop on each ack.
module tb_mire_writer;

  localparam int H = 32;
  localparam int V = 4;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
  } exp_t;

  typedef struct {
    int          x;
    int          y;
    logic [31:0] word;
  } vec_t;

  logic        clk, rst_n;
  logic        en0, ack0, we0, stb0, cyc0, fd0;
  logic [31:0] adr0, dat0;
  logic [3:0]  sel0;
  logic [2:0]  cti0;
  logic [1:0]  bte0;
  logic        en1, ack1, we1, stb1, cyc1, fd1;
  logic [31:0] adr1, dat1;
  logic [3:0]  sel1;
  logic [2:0]  cti1;
  logic [1:0]  bte1;

  int n_tests = 0;
  int n_fail  = 0;
  int ws0 = 0, ws1 = 0;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mem0[int];

  mire_writer #(.HDISP(H), .VDISP(V), .BASE(32'h0), .BURST(64), .CONTINUOUS(0)) u0 (
    .clk(clk), .rst_n(rst_n), .enable(en0), .adr(adr0), .dat_ms(dat0), .we(we0),
    .sel(sel0), .stb(stb0), .cyc(cyc0), .cti(cti0), .bte(bte0), .ack(ack0),
    .frame_done(fd0));

  mire_writer #(.HDISP(H), .VDISP(V), .BASE(32'h0), .BURST(8), .CONTINUOUS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .enable(en1), .adr(adr1), .dat_ms(dat1), .we(we1),
    .sel(sel1), .stb(stb1), .cyc(cyc1), .cti(cti1), .bte(bte1), .ack(ack1),
    .frame_done(fd1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference pixel: byte address by multiplication, pattern by modulo arithmetic.
  function automatic exp_t model(input int idx);
    exp_t e;
    int x, y;
    x = idx % H;
    y = idx / H;
    e.adr = 32'(4 * idx);
    if ((x % 16) == 0 || (y % 16) == 0) e.dat = 32'h00FF_FFFF;
    else e.dat = 32'((x % 256) * 65536 + (y % 256) * 256 + 128);
    return e;
  endfunction

  task automatic push(input int which, input int first, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      if (which == 0) q0.push_back(model(first + i));
      else            q1.push_back(model(first + i));
    end
  endtask

  // Slave models: ack after ws wait states, driven just after the clock edge.
  initial begin
    int w;
    w = 0;
    ack0 = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stb0) begin
        if (w >= ws0) begin ack0 = 1'b1; w = 0; end
        else begin ack0 = 1'b0; w++; end
      end else begin
        ack0 = 1'b0; w = 0;
      end
    end
  end

  initial begin
    int w;
    w = 0;
    ack1 = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stb1) begin
        if (w >= ws1) begin ack1 = 1'b1; w = 0; end
        else begin ack1 = 1'b0; w++; end
      end else begin
        ack1 = 1'b0; w = 0;
      end
    end
  end

  // u0 monitor: scoreboard, hold-while-waiting, frame_done timing.
  int          c0 = 0, last_ack0 = -10, nack0 = 0, fd0_cnt = 0;
  logic        pend0 = 1'b0;
  logic [31:0] padr0 = '0, pdat0 = '0;
  always @(negedge clk) begin
    exp_t e;
    if (stb0 && pend0) begin
      check("hold_adr0", adr0, padr0);
      check("hold_dat0", dat0, pdat0);
    end
    if (stb0 && ack0) begin
      if (q0.size() == 0) check("extra_write0", adr0, 32'hFFFF_FFFF);
      else begin
        e = q0.pop_front();
        check("adr0", adr0, e.adr);
        check("dat0", dat0, e.dat);
      end
      check("we0", 32'(we0), 32'd1);
      mem0[int'(adr0 >> 2)] = dat0;
      last_ack0 = c0;
      nack0++;
    end
    if (fd0) begin
      fd0_cnt++;
      check("fd0_timing", 32'(c0), 32'(last_ack0 + 1));
    end
    pend0 = stb0 && !ack0;
    padr0 = adr0;
    pdat0 = dat0;
    c0++;
  end

  // u1 monitor: scoreboard plus burst length / release gap length.
  logic mon1_on = 1'b0, prev_cyc1 = 1'b0, in_gap1 = 1'b0;
  int   run1 = 0, gap1 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (stb1 && ack1) begin
      if (q1.size() == 0) check("extra_write1", adr1, 32'hFFFF_FFFF);
      else begin
        e = q1.pop_front();
        check("adr1", adr1, e.adr);
        check("dat1", dat1, e.dat);
      end
      run1++;
    end
    if (mon1_on) begin
      if (prev_cyc1 && !cyc1) begin
        check("burst_len1", 32'(run1), 32'd8);
        run1 = 0; gap1 = 1; in_gap1 = 1'b1;
      end else if (in_gap1 && !cyc1) begin
        gap1++;
      end else if (in_gap1 && cyc1) begin
        check("gap_len1", 32'(gap1), 32'd1);
        in_gap1 = 1'b0;
      end
    end
    prev_cyc1 = cyc1;
  end

  initial begin
    vec_t vecs[6];
    bit   done;
    int   k;

    vecs[0] = '{17, 1, 32'h0011_0180};
    vecs[1] = '{16, 2, 32'h00FF_FFFF};
    vecs[2] = '{ 0, 0, 32'h00FF_FFFF};
    vecs[3] = '{ 1, 1, 32'h0001_0180};
    vecs[4] = '{31, 3, 32'h001F_0380};
    vecs[5] = '{ 5, 0, 32'h00FF_FFFF};

    rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctl0", 32'({cyc0, stb0, we0, fd0}), 32'd0);
    check("rst_adr0", adr0, 32'h0);
    check("rst_dat0", dat0, 32'h00FF_FFFF);
    check("rst_ctl1", 32'({cyc1, stb1, we1, fd1}), 32'd0);
    check("consts0", 32'({sel0, cti0, bte0}), 32'({4'hF, 3'd0, 2'd0}));
    rst_n = 1'b1;

    // Idle with enable low: nothing moves.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_ctl0", 32'({cyc0, stb0, we0, fd0}), 32'd0);
      check("idle_adr0", adr0, 32'h0);
      check("idle_dat0", dat0, 32'h00FF_FFFF);
    end

    // Full frame, ack every cycle.
    push(0, 0, H * V);
    en0 = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (fd0) done = 1'b1;
    end
    en0 = 1'b0;
    check("frame0_done", 32'(done), 32'd1);
    check("frame0_q_empty", 32'(q0.size()), 32'd0);
    check("frame0_idle", 32'({cyc0, stb0}), 32'd0);
    @(negedge clk);
    check("frame0_adr_base", adr0, 32'h0);
    repeat (5) @(negedge clk);
    check("frame0_fd_once", 32'(fd0_cnt), 32'd1);
    check("frame0_stay_idle", 32'(cyc0), 32'd0);
    for (int i = 0; i < 6; i++)
      check($sformatf("pix_%0d_%0d", vecs[i].x, vecs[i].y),
            mem0[vecs[i].y * H + vecs[i].x], vecs[i].word);

    // Wait states, then drop enable with an ack pending and resume later.
    push(0, 0, H * V);
    ws0 = 3;
    en0 = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (nack0 >= 5 && stb0 && !ack0) done = 1'b1;
    end
    check("drop_reach", 32'(done), 32'd1);
    en0 = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (stb0 && ack0) done = 1'b1;
    end
    check("drop_ack", 32'(done), 32'd1);
    @(negedge clk);
    check("drop_cyc0", 32'(cyc0), 32'd0);
    k = nack0;
    repeat (8) @(negedge clk);
    check("drop_hold_cyc0", 32'(cyc0), 32'd0);
    check("drop_no_ack", 32'(nack0), 32'(k));
    ws0 = 0;
    en0 = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (fd0) done = 1'b1;
    end
    en0 = 1'b0;
    check("resume_done", 32'(done), 32'd1);
    check("resume_q_empty", 32'(q0.size()), 32'd0);

    // Continuous mode with 8-word bursts.
    push(1, 0, H * V);
    push(1, 0, 16);
    mon1_on = 1'b1;
    en1 = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      if (fd1) done = 1'b1;
    end
    check("cont_done", 32'(done), 32'd1);
    check("cont_q_left", 32'(q1.size()), 32'd16);
    check("cont_gap", 32'(cyc1), 32'd0);
    @(negedge clk);
    check("cont_restart", 32'({cyc1, stb1}), 32'd3);
    check("cont_adr_base", adr1, 32'h0);
    repeat (3) @(negedge clk);
    check("mid_burst_busy", 32'(cyc1), 32'd1);

    // Asynchronous reset mid-burst.
    mon1_on = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ctl1", 32'({cyc1, stb1, we1}), 32'd0);
    check("async_rst_adr1", adr1, 32'h0);
    check("async_rst_dat1", dat1, 32'h00FF_FFFF);
    en1 = 1'b0;
    q1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle1", 32'({cyc1, stb1}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
